// File: rtl/fibo_bcd_converter_pkg.sv
// fibo_pkg -- shared types and constants for the Fibonacci BCD converter.
//   state_t            : converter FSM states (IDLE / SHIFT / HOLD)
//   bcd_digit_t        : one packed BCD digit
//   BCD_ADJ_THRESHOLD  : digit value at or above which double-dabble adds a correction
//   BCD_ADJ_VALUE      : correction added before each shift
//   bcd_digits_needed  : decimal digits required to show any DATA_WIDTH-bit value
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ_THRESHOLD = 4'd5;
  localparam bcd_digit_t BCD_ADJ_VALUE     = 4'd3;

  // ceil(width * log10(2)); 0.30103 is accurate enough that no realistic
  // width lands on the wrong side of an integer boundary.
  function automatic int bcd_digits_needed(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/fibo_bcd_converter_if.sv
// fibo_bcd_converter_if -- request/result bundle between the Fibonacci
// generator side (master) and the BCD converter (slave).
//   start, bin_in, ovf_in : conversion request (master -> slave)
//   in_ready, busy        : converter status (slave -> master)
//   out_valid, bcd, ovf   : result, valid/ready handshake (slave -> master)
//   out_ready             : consumer accepts the result (master -> slave)
interface fibo_bcd_converter_if
  import fibo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DIGITS     = 20
);

  logic                    start;
  logic [DATA_WIDTH-1:0]   bin_in;
  logic                    ovf_in;
  logic                    in_ready;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*DIGITS-1:0]     bcd;
  logic                    ovf;

  modport master (
    output start, bin_in, ovf_in, out_ready,
    input  in_ready, busy, out_valid, bcd, ovf
  );

  modport slave (
    input  start, bin_in, ovf_in, out_ready,
    output in_ready, busy, out_valid, bcd, ovf
  );

endinterface

// File: rtl/fibo_bcd_converter_digit_adj.sv
// bcd_digit_adj -- double-dabble correction cell for one BCD digit.
//   din  : digit before the shift
//   dout : din + 3 when din >= 5, otherwise din (4-bit, no carry out)
module bcd_digit_adj
  import fibo_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= BCD_ADJ_THRESHOLD) ? bcd_digit_t'(din + BCD_ADJ_VALUE) : din;

endmodule

// File: rtl/fibo_bcd_converter.sv
// fibo_bcd_converter -- sequential double-dabble binary to packed BCD converter.
// Captures a finished generator result and converts it one bit per clock
// (DATA_WIDTH cycles), then presents it on a valid/ready output.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : fibo_bcd_converter_if.slave (start/bin_in/ovf_in request,
//            in_ready/busy status, out_valid/out_ready/bcd/ovf result)
// Optional build macro FIBO_BCD_EDGE_START_EN: start is taken as a level and
// only its 0->1 edge, seen while idle, launches a conversion.
module fibo_bcd_converter
  import fibo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DIGITS     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  fibo_bcd_converter_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  // Elaboration-time parameter sanity checks.
  generate
    if (DATA_WIDTH < 4) begin : g_bad_width
      $error("fibo_bcd_converter: DATA_WIDTH must be >= 4");
    end
    if (DIGITS < bcd_digits_needed(DATA_WIDTH)) begin : g_bad_digits
      $error("fibo_bcd_converter: DIGITS too small for DATA_WIDTH");
    end
  endgenerate

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  shift_reg, shift_next;
  logic [BCD_W-1:0]       acc_reg,   acc_next;
  logic [CNT_W-1:0]       cnt_reg,   cnt_next;
  logic [BCD_W-1:0]       bcd_reg,   bcd_next;
  logic                   ovf_reg,   ovf_next;

  logic [BCD_W-1:0]             acc_adj;
  logic [BCD_W+DATA_WIDTH-1:0]  dabble;
  logic                         start_fire;
  logic                         in_ready_comb;
  logic                         busy_comb;
  logic                         out_valid_comb;

  // ---------------------------------------------------------------------------
  // Start qualification
  // ---------------------------------------------------------------------------
`ifdef FIBO_BCD_EDGE_START_EN
  logic start_d_reg;

  // The delayed copy tracks start in every state, so an edge that occurs while
  // busy is consumed there and never fires later in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d_reg <= 1'b0;
    end else begin
      start_d_reg <= bus.start;
    end
  end

  assign start_fire = bus.start & ~start_d_reg;
`else
  assign start_fire = bus.start;
`endif

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction, then one combined left shift of {bcd, bin}.
  // The top bit of the corrected accumulator falls off the end; it is always
  // zero when DIGITS is large enough.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (acc_reg[4*gi +: 4]),
        .dout (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign dabble = {acc_adj, shift_reg} << 1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      bcd_reg   <= bcd_next;
      ovf_reg   <= ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    bcd_next       = bcd_reg;
    ovf_next       = ovf_reg;
    in_ready_comb  = 1'b0;
    busy_comb      = 1'b0;
    out_valid_comb = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready_comb = 1'b1;
        if (start_fire) begin
          if (bus.ovf_in) begin
            // Overflowed result: no number to convert, publish the marker.
            bcd_next   = '0;
            ovf_next   = 1'b1;
            state_next = HOLD;
          end else begin
            shift_next = bus.bin_in;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        busy_comb  = 1'b1;
        acc_next   = dabble[BCD_W+DATA_WIDTH-1 -: BCD_W];
        shift_next = dabble[DATA_WIDTH-1:0];
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT) begin
          bcd_next   = dabble[BCD_W+DATA_WIDTH-1 -: BCD_W];
          ovf_next   = 1'b0;
          state_next = HOLD;
        end
      end

      HOLD: begin
        out_valid_comb = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_comb;
  assign bus.busy      = busy_comb;
  assign bus.out_valid = out_valid_comb;
  assign bus.bcd       = bcd_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// tb_fibo_bcd_converter -- self-checking bench for fibo_bcd_converter.
// Directed table of test-plan values, hand-written multi-cycle sequences
// (hold/back-pressure, reset mid-conversion, held start) and randomized
// values checked against a divide-by-ten decimal model.
module tb_fibo_bcd_converter;

  localparam int DW = 64;
  localparam int ND = 20;
  localparam int CONV_LAT = DW + 1;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  fibo_bcd_converter_if #(.DATA_WIDTH(DW), .DIGITS(ND)) bus ();

  fibo_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [DW-1:0]   bin;
    logic            ovf_in;
    logic [4*ND-1:0] exp_bcd;
  } vec_t;

  vec_t tbl [6];

  // Decimal reference: plain repeated division by ten.
  function automatic logic [4*ND-1:0] to_bcd(input logic [DW-1:0] v);
    logic [4*ND-1:0] r = '0;
    logic [DW-1:0]   x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4*ND-1:0] act, input logic [4*ND-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues a one-cycle start and waits (bounded) for out_valid.
  task automatic run_conv(input logic [DW-1:0] b, input logic o,
                          output int lat, output logic ir_bad);
    bus.start  = 1'b1;
    bus.bin_in = b;
    bus.ovf_in = o;
    step();
    bus.start = 1'b0;
    lat    = 1;
    ir_bad = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) ir_bad = 1'b1;
      step();
      lat++;
    end
    if (bus.in_ready) ir_bad = 1'b1;
  endtask

  task automatic handshake(input logic [4*ND-1:0] exp_bcd, input logic exp_ovf);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("valid_drop", 80'(bus.out_valid), 80'(0));
    check("ready_back", 80'(bus.in_ready), 80'(1));
    check("bcd_retain", bus.bcd, exp_bcd);
    check("ovf_retain", 80'(bus.ovf), 80'(exp_ovf));
  endtask

  task automatic full_conv(input string tag, input logic [DW-1:0] b, input logic o,
                           input logic [4*ND-1:0] exp_bcd);
    int   lat;
    logic ir_bad;
    run_conv(b, o, lat, ir_bad);
    $display("%s: bin=%0d ovf_in=%0b bcd=%h ovf=%0b latency=%0d", tag, b, o, bus.bcd, bus.ovf, lat);
    check({tag, "_latency"}, 80'(lat), 80'(o ? 1 : CONV_LAT));
    check({tag, "_inready_low"}, 80'(ir_bad), 80'(0));
    check({tag, "_valid"}, 80'(bus.out_valid), 80'(1));
    check({tag, "_bcd"}, bus.bcd, exp_bcd);
    check({tag, "_ovf"}, 80'(bus.ovf), 80'(o));
    handshake(exp_bcd, o);
  endtask

  initial begin
    int              lat;
    logic            ir_bad;
    int              nvalid;
    int              exp_nvalid;
    int              guard;
    logic [DW-1:0]   rv;
    logic            ro;
    int              w;

    tbl[0] = '{64'd0,                   1'b0, 80'h0};
    tbl[1] = '{64'd12345,               1'b0, 80'h12345};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 80'h18446744073709551615};
    tbl[3] = '{64'd7,                   1'b1, 80'h0};
    tbl[4] = '{64'd89,                  1'b0, 80'h89};
    tbl[5] = '{64'd10000000000000000000, 1'b0, 80'h10000000000000000000};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bin_in    = '0;
    bus.ovf_in    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_in_ready", 80'(bus.in_ready), 80'(1));
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_valid", 80'(bus.out_valid), 80'(0));
    check("rst_ovf", 80'(bus.ovf), 80'(0));
    check("rst_bcd", bus.bcd, 80'h0);
    reset = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      full_conv($sformatf("tbl%0d", i), tbl[i].bin, tbl[i].ovf_in, tbl[i].exp_bcd);
    end

    // Back-pressure: result held 10 cycles, stray starts during SHIFT/HOLD ignored
    bus.start  = 1'b1;
    bus.bin_in = 64'd89;
    bus.ovf_in = 1'b0;
    step();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (lat == 10) begin
        bus.start  = 1'b1;
        bus.bin_in = 64'd999;
        bus.ovf_in = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (lat == 5) check("shift_busy", 80'(bus.busy), 80'(1));
      step();
      lat++;
    end
    bus.start = 1'b0;
    $display("hold89: bcd=%h latency=%0d", bus.bcd, lat);
    check("hold89_latency", 80'(lat), 80'(CONV_LAT));
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 80'(bus.out_valid), 80'(1));
      check("hold_bcd", bus.bcd, 80'h89);
      check("hold_ovf", 80'(bus.ovf), 80'(0));
      bus.start  = (i % 3 == 0);
      bus.bin_in = 64'd5;
      bus.ovf_in = 1'b1;
      step();
    end
    // start together with out_ready in the last HOLD cycle is ignored
    bus.start     = 1'b1;
    bus.bin_in    = 64'd3;
    bus.ovf_in    = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("hold_exit_valid", 80'(bus.out_valid), 80'(0));
    check("hold_exit_idle", 80'(bus.in_ready), 80'(1));
    check("hold_exit_bcd", bus.bcd, 80'h89);
    check("hold_exit_ovf", 80'(bus.ovf), 80'(0));
    step();
    check("start_with_ready_ignored", 80'(bus.in_ready), 80'(1));

    // Reset in SHIFT cycle 30 discards the conversion
    bus.start  = 1'b1;
    bus.bin_in = 64'd12345;
    bus.ovf_in = 1'b0;
    step();
    bus.start = 1'b0;
    repeat (29) step();
    check("pre_reset_busy", 80'(bus.busy), 80'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset_mid_shift: in_ready=%0b bcd=%h", bus.in_ready, bus.bcd);
    check("midrst_in_ready", 80'(bus.in_ready), 80'(1));
    check("midrst_busy", 80'(bus.busy), 80'(0));
    check("midrst_valid", 80'(bus.out_valid), 80'(0));
    check("midrst_bcd", bus.bcd, 80'h0);
    check("midrst_ovf", 80'(bus.ovf), 80'(0));
    full_conv("after_reset", 64'd55, 1'b0, 80'h55);

    // start held high for 200 cycles with an always-ready consumer
    bus.start     = 1'b1;
    bus.bin_in    = 64'd144;
    bus.ovf_in    = 1'b0;
    bus.out_ready = 1'b1;
    nvalid = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (bus.out_valid) begin
        nvalid++;
        check("held_bcd", bus.bcd, 80'h144);
      end
    end
`ifdef FIBO_BCD_EDGE_START_EN
    exp_nvalid = 1;
`else
    // One conversion occupies IDLE + DW SHIFT + HOLD cycles.
    exp_nvalid = (200 - CONV_LAT) / (DW + 2) + 1;
`endif
    $display("held_start: conversions=%0d", nvalid);
    check("held_conversions", 80'(nvalid), 80'(exp_nvalid));
    bus.start = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 150) begin
      step();
      guard++;
    end
    check("drain_idle", 80'(bus.in_ready), 80'(1));
    bus.out_ready = 1'b0;
    step();

    // Randomized values against the decimal model
    for (int i = 0; i < 24; i++) begin
      w  = $urandom_range(1, DW);
      rv = {$urandom, $urandom};
      rv = rv >> (DW - w);
      ro = ($urandom_range(0, 7) == 0);
      full_conv($sformatf("rnd%0d", i), rv, ro, ro ? 80'h0 : to_bcd(rv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fibo_bcd_converter.md
Name: fibo_bcd_converter

Overview:
- Downstream stage of the Fibonacci generator: captures a finished binary result plus overflow flag and converts it to packed BCD digits for display/UART formatting.
- Sequential double-dabble: one bit per cycle, DATA_WIDTH cycles per conversion.
- Valid/ready output handshake lets a slow consumer back-pressure; input side is a start pulse gated by in_ready.

Parameters:
- DATA_WIDTH, 64, width of binary input; must be >= 4.
- DIGITS, 20, number of BCD digits; must be >= ceil(DATA_WIDTH*log10(2)), checked by elaboration assertion.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin_in/ovf_in; accepted only when in_ready=1.
- bin_in  input  DATA_WIDTH  binary value (generator result).
- ovf_in  input  1  overflow flag (generator carry).
- in_ready  output  1  high only in IDLE.
- busy  output  1  high in SHIFT.
- out_valid  output  1  high in HOLD; result stable while high.
- out_ready  input  1  consumer accepts result.
- bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- ovf  output  1  result is an overflow marker, not a number.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, in_ready=1, busy=0, out_valid=0, ovf=0, bcd=0, shift register and bit counter cleared. Reset wins over all other inputs, including mid-SHIFT and mid-HOLD; partial conversion discarded.
- States: IDLE, SHIFT, HOLD (enum from package).
- IDLE: on start=1 with ovf_in=0: load bin_in into shift reg, clear BCD accumulator, counter=0, go SHIFT. On start=1 with ovf_in=1: bcd=0, ovf=1, go HOLD directly (latency 1). start with ovf_in=1 takes precedence over bin_in content.
- SHIFT: each cycle, every digit >=5 gets +3 (combinational per digit), then {BCD, bin} shifted left by 1; counter increments. After DATA_WIDTH shifts (counter==DATA_WIDTH-1 on the shifting cycle) go HOLD with bcd=final accumulator, ovf=0.
- Latency: start accepted in cycle 0 -> out_valid high in cycle DATA_WIDTH+1 (65 at defaults); ovf path: cycle 1.
- HOLD: out_valid=1, bcd/ovf held stable. out_ready=1 -> go IDLE next cycle; out_valid drops, bcd/ovf retain last value.
- start while SHIFT or HOLD: ignored (no queuing, no corruption). start and out_ready in same HOLD cycle: start ignored; new start accepted from following IDLE cycle.
- Width rules: digit correction is 4-bit, no carry between digits beyond the shift; unused top digits (DIGITS larger than required) always 0.
- bin_in=0: full DATA_WIDTH-cycle conversion, bcd=0 (no early exit).

Optional Feature:
- Macro FIBO_BCD_EDGE_START_EN.
- Defined: start is treated as a level (e.g. wired straight to generator done); a registered copy forms a rising-edge pulse, conversion triggers only on 0->1 edge seen while in IDLE; edge register reset to 0. An edge arriving outside IDLE is dropped.
- Undefined: start is used as-is; a held-high start retriggers a new conversion in every IDLE cycle.

Decomposition:
- Package fibo_pkg: state enum (IDLE/SHIFT/HOLD), bcd_digit_t (4-bit logic), function bcd_digits_needed(width) for the DIGITS assertion, localparam BCD_ADJ_THRESHOLD=5, BCD_ADJ_VALUE=3.
- Sub-module bcd_digit_adj: combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times via generate.

Test Plan:
- Reset, start with bin_in=0, ovf_in=0 -> in cycle 65 out_valid=1, bcd=0, ovf=0; in_ready low cycles 1-65.
- bin_in=12345 -> bcd low 20 bits = 0x12345, upper digits 0; bin_in=2^64-1 -> bcd=0x18446744073709551615 (all 20 digits).
- start with ovf_in=1, bin_in=7 -> next cycle out_valid=1, ovf=1, bcd=0.
- bin_in=89, out_ready held low 10 cycles after valid -> out_valid and bcd=0x89 stable throughout; start pulses during SHIFT/HOLD ignored; out_ready=1 -> IDLE next cycle.
- reset asserted at SHIFT cycle 30 -> next cycle IDLE, all outputs 0; fresh start bin_in=55 -> bcd=0x55 at cycle 65.
- With FIBO_BCD_EDGE_START_EN: start held high 200 cycles, bin_in=144 -> exactly one conversion (bcd=0x144); without macro -> second conversion begins right after handshake.
